// File: rtl/eth_vlg_hdr_rx.sv
// eth_vlg_hdr_rx
// Receive-side header extractor. Collects the first HDR_LEN bytes of each
// packet into a flat vector (byte 0 at the MSBs, so it casts directly onto the
// packed protocol header structs), optionally validates the 16-bit
// ones'-complement header checksum, and forwards the rest of the packet as a
// payload stream with one cycle of latency.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_dat/val/sof/eof input byte stream, W bytes per beat, no backpressure
//   hdr, hdr_val      captured header and its one-cycle valid pulse
//   chsum_ok          folded checksum == 16'hFFFF (tied 1 when CHSUM_EN=0)
//   err_short         one-cycle pulse: packet ended/restarted inside header
//   pld_dat/val/sof/eof payload stream
//   busy              high while collecting a header or forwarding payload
module eth_vlg_hdr_rx #(
  parameter int W        = 1,
  parameter int HDR_LEN  = 20,
  parameter int CHSUM_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [W*8-1:0]       in_dat,
  input  logic                 in_val,
  input  logic                 in_sof,
  input  logic                 in_eof,
  output logic [HDR_LEN*8-1:0] hdr,
  output logic                 hdr_val,
  output logic                 chsum_ok,
  output logic                 err_short,
  output logic [W*8-1:0]       pld_dat,
  output logic                 pld_val,
  output logic                 pld_sof,
  output logic                 pld_eof,
  output logic                 busy
);

  localparam int NB = HDR_LEN / W;          // header beats
  localparam int CW = $clog2(NB) + 1;
  localparam int HB = HDR_LEN * 8;
  localparam int DW = W * 8;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PLD} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     acc_q, acc_d;
  logic [HB-1:0]   hdr_buf_q, hdr_buf_d;
  logic [HB-1:0]   hdr_q, hdr_d;
  logic            hdr_val_q, hdr_val_d;
  logic            chsum_ok_q, chsum_ok_d;
  logic            err_short_q, err_short_d;
  logic [DW-1:0]   pld_dat_q, pld_dat_d;
  logic            pld_val_q, pld_val_d;
  logic            pld_sof_q, pld_sof_d;
  logic            pld_eof_q, pld_eof_d;
  logic            first_q, first_d;   // next payload beat is the first one

  // Beat decode
  logic            take_sof, take_hdr, hdr_done, hdr_short, take_pld;
  logic [CW-1:0]   slot;
  logic [31:0]     beat_sum;
  logic [16:0]     fold1, fold2;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. An in_sof beat always starts a new header, whatever
  // state we are in; in_eof always returns to idle.
  always_comb begin
    state_d = state_q;
    if (take_hdr) begin
      if (in_eof)        state_d = S_IDLE;
      else if (hdr_done) state_d = S_PLD;
      else               state_d = S_HDR;
    end else if (take_pld && in_eof) begin
      state_d = S_IDLE;
    end
  end

  // Output / control decode
  always_comb begin
    take_sof  = in_val & in_sof;
    take_hdr  = take_sof | (in_val & (state_q == S_HDR));
    slot      = take_sof ? '0 : cnt_q;
    hdr_done  = take_hdr & (slot == LAST);
    // A restart inside the header is an error; so is an eof before the last
    // header beat (including a one-beat packet when the header spans beats).
    hdr_short = (take_sof & (state_q == S_HDR)) | (take_hdr & ~hdr_done & in_eof);
    take_pld  = in_val & ~in_sof & (state_q == S_PLD);
  end

  // Datapath next values
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    hdr_buf_d   = hdr_buf_q;
    hdr_d       = hdr_q;
    hdr_val_d   = 1'b0;
    chsum_ok_d  = chsum_ok_q;
    err_short_d = hdr_short;
    pld_val_d   = take_pld;
    pld_dat_d   = take_pld ? in_dat : pld_dat_q;
    pld_sof_d   = take_pld & first_q;
    pld_eof_d   = take_pld & in_eof;
    first_d     = take_pld ? 1'b0 : first_q;

    // Sum of the big-endian 16-bit words carried by this beat. With one byte
    // per beat the slot parity says whether it is the high or low byte.
    beat_sum = '0;
    if (W == 1) begin
      beat_sum = slot[0] ? {24'h0, in_dat[7:0]} : {16'h0, in_dat[7:0], 8'h0};
    end else begin
      for (int i = 0; i < W / 2; i++)
        beat_sum = beat_sum + {16'h0, in_dat[DW-1-16*i -: 16]};
    end

    if (take_hdr) begin
      hdr_buf_d[HB - (int'(slot) + 1) * DW +: DW] = in_dat;
      acc_d = (take_sof ? 32'h0 : acc_q) + beat_sum;
      cnt_d = (hdr_done || in_eof) ? '0 : slot + 1'b1;
    end

    fold1 = {1'b0, acc_d[15:0]} + {1'b0, acc_d[31:16]};
    fold2 = {1'b0, fold1[15:0]} + {16'h0, fold1[16]};

    if (hdr_done) begin
      hdr_d      = hdr_buf_d;
      hdr_val_d  = 1'b1;
      chsum_ok_d = (fold2[15:0] == 16'hFFFF);
      first_d    = 1'b1;
    end
  end

  // NOTE: the header buffer is reset along with everything else; it is a
  // plain register bank, and clearing it keeps hdr at 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      hdr_buf_q   <= '0;
      hdr_q       <= '0;
      hdr_val_q   <= 1'b0;
      chsum_ok_q  <= 1'b0;
      err_short_q <= 1'b0;
      pld_dat_q   <= '0;
      pld_val_q   <= 1'b0;
      pld_sof_q   <= 1'b0;
      pld_eof_q   <= 1'b0;
      first_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      hdr_buf_q   <= hdr_buf_d;
      hdr_q       <= hdr_d;
      hdr_val_q   <= hdr_val_d;
      chsum_ok_q  <= chsum_ok_d;
      err_short_q <= err_short_d;
      pld_dat_q   <= pld_dat_d;
      pld_val_q   <= pld_val_d;
      pld_sof_q   <= pld_sof_d;
      pld_eof_q   <= pld_eof_d;
      first_q     <= first_d;
    end
  end

  assign hdr       = hdr_q;
  assign hdr_val   = hdr_val_q;
  assign chsum_ok  = (CHSUM_EN != 0) ? chsum_ok_q : 1'b1;
  assign err_short = err_short_q;
  assign pld_dat   = pld_dat_q;
  assign pld_val   = pld_val_q;
  assign pld_sof   = pld_sof_q;
  assign pld_eof   = pld_eof_q;
  assign busy      = (state_q != S_IDLE);

endmodule
